// File: rtl/uart_rx_fifo.sv
// 16x-oversampled UART receiver (8N1; even parity when UART_RX_PARITY_EN is defined) feeding a 16-deep FWFT FIFO.
// Byte reaches the FIFO head one clk after its stop-bit decision; a push into a full FIFO with no pop is dropped and flagged.
module uart_rx_fifo #(
  parameter int CLK_RATE = 84000000,
  parameter int BAUD     = 115200,
  parameter int FIFO_AW  = 4
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic               rx,
  input  logic               rd,
  output logic [7:0]         dout,
  output logic               empty,
  output logic [FIFO_AW:0]   count,
  output logic               byte_strobe,
  output logic               frame_err,
  output logic               overrun,
`ifdef UART_RX_PARITY_EN
  output logic               parity_err,
`endif
  input  logic               clr_err
);

  localparam int DIV   = (CLK_RATE + 8 * BAUD) / (16 * BAUD);
  localparam int DW    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [DW-1:0]      DIV_LAST = DW'(DIV - 1);
  localparam logic [DW-1:0]      DIV_ONE  = DW'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);
  localparam logic [FIFO_AW:0]   CNT_ONE  = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW:0]   CNT_FULL = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  logic [1:0]         r_sync;
  logic               r_rx_q;
  state_t             r_state;
  logic [DW-1:0]      r_div;
  logic [3:0]         r_tick;
  logic [2:0]         r_bit;
  logic               r_s7;
  logic               r_s8;
  logic [7:0]         r_shift;

  logic [7:0]         r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wptr;
  logic [FIFO_AW-1:0] r_rptr;
  logic [FIFO_AW:0]   r_count;
  logic               r_strobe;
  logic               r_frame_err;
  logic               r_overrun;

  logic w_rx;
  logic w_fall;
  logic w_busy;
  logic w_tick;
  logic w_maj;
  logic w_dec;
  logic w_push;
  logic w_ferr;
  logic w_full;
  logic w_pop;
  logic w_wr;
  logic w_drop;

  assign w_rx   = r_sync[1];
  // Start needs a seen-high line: r_rx_q resets low, so a line held low out of reset never triggers.
  assign w_fall = r_rx_q & ~w_rx;
  assign w_busy = (r_state != S_IDLE) && (r_state != S_BREAK);
  assign w_tick = (r_div == DIV_LAST);
  assign w_maj  = (r_s7 & r_s8) | (r_s7 & w_rx) | (r_s8 & w_rx);
  assign w_dec  = w_busy && w_tick && (r_tick == 4'd9);
  assign w_ferr = w_dec && (r_state == S_STOP) && !w_maj;

`ifdef UART_RX_PARITY_EN
  logic r_par_bad;
  logic r_parity_err;
  logic w_perr;
  assign w_perr     = w_dec && (r_state == S_PARITY) && (w_maj != ^r_shift);
  assign w_push     = w_dec && (r_state == S_STOP) && w_maj && !r_par_bad;
  assign parity_err = r_parity_err;
`else
  assign w_push     = w_dec && (r_state == S_STOP) && w_maj;
`endif

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_sync  <= 2'b00;
      r_rx_q  <= 1'b0;
      r_state <= S_IDLE;
      r_div   <= '0;
      r_tick  <= 4'd0;
      r_bit   <= 3'd0;
      r_s7    <= 1'b0;
      r_s8    <= 1'b0;
      r_shift <= 8'h00;
`ifdef UART_RX_PARITY_EN
      r_par_bad <= 1'b0;
`endif
    end else begin
      r_sync <= {r_sync[0], rx};
      r_rx_q <= w_rx;
      case (r_state)
        S_IDLE: begin
          if (w_fall) begin
            r_state <= S_START;
            r_div   <= '0;
            r_tick  <= 4'd0;
          end
        end
        S_BREAK: begin
          if (w_rx) r_state <= S_IDLE;
        end
        default: begin
          r_div <= w_tick ? '0 : r_div + DIV_ONE;
          if (w_tick) begin
            r_tick <= r_tick + 4'd1;
            if (r_tick == 4'd7) r_s7 <= w_rx;
            if (r_tick == 4'd8) r_s8 <= w_rx;
          end
          if (w_dec) begin
            case (r_state)
              S_START: begin
                if (w_maj) begin
                  r_state <= S_IDLE;
                end else begin
                  r_state <= S_DATA;
                  r_bit   <= 3'd0;
`ifdef UART_RX_PARITY_EN
                  r_par_bad <= 1'b0;
`endif
                end
              end
              S_DATA: begin
                r_shift <= {w_maj, r_shift[7:1]};
                r_bit   <= r_bit + 3'd1;
`ifdef UART_RX_PARITY_EN
                if (r_bit == 3'd7) r_state <= S_PARITY;
`else
                if (r_bit == 3'd7) r_state <= S_STOP;
`endif
              end
`ifdef UART_RX_PARITY_EN
              S_PARITY: begin
                r_par_bad <= (w_maj != ^r_shift);
                r_state   <= S_STOP;
              end
`endif
              // Leaving mid stop bit lets the next start edge be caught early.
              default: r_state <= w_maj ? S_IDLE : S_BREAK;
            endcase
          end
        end
      endcase
    end
  end

  assign w_full = (r_count == CNT_FULL);
  assign w_pop  = rd && (r_count != '0);
  assign w_wr   = w_push && (!w_full || w_pop);
  assign w_drop = w_push && w_full && !w_pop;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= 8'h00;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_strobe    <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_err <= 1'b0;
`endif
    end else begin
      if (w_wr) begin
        r_mem[r_wptr] <= r_shift;
        r_wptr        <= r_wptr + PTR_ONE;
      end
      if (w_pop) r_rptr <= r_rptr + PTR_ONE;
      if (w_wr && !w_pop)      r_count <= r_count + CNT_ONE;
      else if (!w_wr && w_pop) r_count <= r_count - CNT_ONE;
      r_strobe <= w_wr;
      // A new error event in the same cycle as clr_err wins.
      r_frame_err <= w_ferr || (r_frame_err && !clr_err);
      r_overrun   <= w_drop || (r_overrun && !clr_err);
`ifdef UART_RX_PARITY_EN
      r_parity_err <= w_perr || (r_parity_err && !clr_err);
`endif
    end
  end

  assign dout        = r_mem[r_rptr];
  assign empty       = (r_count == '0);
  assign count       = r_count;
  assign byte_strobe = r_strobe;
  assign frame_err   = r_frame_err;
  assign overrun     = r_overrun;

endmodule
